// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   L       : instruction address width (matches the program counter)
//   W       : instruction word width
//   HALT_OP : opcode that ends the program
//   fetch_entry_t : one {pc, instruction} pair held in the prefetch FIFO
//   fetch_state_t : fetch unit control states
package fetch_pkg;

  localparam int L = 10;
  localparam int W = 9;
  localparam logic [W-1:0] HALT_OP = 9'h1FF;

  typedef struct packed {
    logic [L-1:0] pc;
    logic [W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH-entry circular buffer of fetch_entry_t.
//   Clk, Reset : clock, synchronous active-high reset (empties the buffer)
//   flush      : empty the buffer; wins over push and pop
//   push       : write push_entry at the tail
//   push_entry : {pc, instruction} pair to store
//   pop        : retire the head entry
//   count      : number of valid entries
//   head       : entry at the read pointer (meaningful while count != 0)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity lives in count and the pointers.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // The issue-side credit check must make this impossible.
  always_ff @(posedge Clk) begin
    if (!Reset) assert (!(do_push && count == CW'(DEPTH)));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts fetch addresses from the program counter,
// reads the 1-cycle-latency instruction ROM, buffers {pc, inst} pairs and
// hands them to the decoder with valid/ready.
//   Clk, Reset          : clock, synchronous active-high reset
//   Start               : begin (or restart) a program; flushes the FIFO
//   PcIn/PcValid/PcReady: fetch address handshake from the program counter
//   Redirect            : taken branch; flushes the wrong path
//   ImemAddr/ImemRdEn   : ROM read request
//   ImemData            : ROM data, one cycle after ImemRdEn
//   InstOut/InstPc      : head instruction and its address
//   InstValid/InstReady : decoder handshake
//   Done                : halt opcode retired; held until Start or Reset
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [L-1:0] PcIn,
  input  logic         PcValid,
  output logic         PcReady,
  input  logic         Redirect,
  output logic [L-1:0] ImemAddr,
  output logic         ImemRdEn,
  input  logic [W-1:0] ImemData,
  output logic [W-1:0] InstOut,
  output logic [L-1:0] InstPc,
  output logic         InstValid,
  input  logic         InstReady,
  output logic         Done
);

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_d;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          credit_ok;
  logic          accept;
  logic          pop;
  logic          halt_pop;
  logic          flush;
  logic          push;
  logic          vld_p1;
  logic          kill_p1;
  logic [L-1:0]  inflight_pc_p1;

  // Credit counts both buffered entries and the read still in the ROM, so a
  // push can never find the FIFO full. Registered terms only.
  assign credit_ok = ({1'b0, count} + {{CW{1'b0}}, vld_p1}) < DEPTH_C;
  assign PcReady   = (state == RUN) && !Redirect && credit_ok;
  assign accept    = PcValid && PcReady;
  assign ImemRdEn  = accept;
  assign ImemAddr  = accept ? PcIn : '0;

  assign InstValid = (state == RUN) && (count != '0);
  assign InstOut   = InstValid ? head.inst : '0;
  assign InstPc    = InstValid ? head.pc : '0;
  assign pop       = InstValid && InstReady;
  assign halt_pop  = pop && (head.inst == HALT_OP);
  assign Done      = (state == HALT);

  // A flush drops the read landing this cycle (flush beats push in the FIFO);
  // kill_p1 drops the read accepted in the flush cycle when it lands.
  assign push       = vld_p1 && !kill_p1;
  assign push_entry = '{pc: inflight_pc_p1, inst: ImemData};

  always_comb begin
    state_d = state;
    flush   = Redirect || Start;
    case (state)
      IDLE: if (Start) state_d = RUN;
      RUN: begin
        // Start restarts in place; otherwise the halt pop wins over Redirect.
        if (!Start && halt_pop) begin
          state_d = HALT;
          flush   = 1'b1;
        end
      end
      HALT: if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      kill_p1 <= 1'b0;
    end else begin
      state   <= state_d;
      vld_p1  <= accept;
      kill_p1 <= flush;
    end
  end

  // Stage p0 -> p1: address of the read now inside the ROM.
  always_ff @(posedge Clk) begin
    if (accept) inflight_pc_p1 <= PcIn;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 3;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [L-1:0] PcIn;
  logic         PcValid;
  logic         PcReady;
  logic         Redirect;
  logic [L-1:0] ImemAddr;
  logic         ImemRdEn;
  logic [W-1:0] ImemData;
  logic [W-1:0] InstOut;
  logic [L-1:0] InstPc;
  logic         InstValid;
  logic         InstReady;
  logic         Done;

  always #5 Clk = ~Clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .PcIn      (PcIn),
    .PcValid   (PcValid),
    .PcReady   (PcReady),
    .Redirect  (Redirect),
    .ImemAddr  (ImemAddr),
    .ImemRdEn  (ImemRdEn),
    .ImemData  (ImemData),
    .InstOut   (InstOut),
    .InstPc    (InstPc),
    .InstValid (InstValid),
    .InstReady (InstReady),
    .Done      (Done)
  );

  // Synchronous ROM with one cycle of read latency.
  logic [W-1:0] rom [0:(1<<L)-1];
  always @(posedge Clk) if (ImemRdEn) ImemData <= rom[ImemAddr];

  int checks = 0;
  int errors = 0;

  // Reference model: program state (0 idle, 1 running, 2 halted) and the list
  // of accepted-but-undelivered fetches with the cycle each was accepted in.
  int           mstate;
  int           cyc;
  logic [L-1:0] q_pc [$];
  int           q_t  [$];
  bit           acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q_pc.delete();
    q_t.delete();
  endtask

  // One clock: compare outputs to the model, then advance the model at the edge.
  task automatic step();
    bit run, erdy, eval, popd, hlt;
    #1;
    run  = (mstate == 1);
    erdy = run && !Redirect && (q_pc.size() < DEPTH);
    acc  = PcValid && erdy;
    eval = run && (q_pc.size() > 0) && ((cyc - q_t[0]) >= 2);
    chk("PcReady", 32'(PcReady), 32'(erdy));
    chk("ImemRdEn", 32'(ImemRdEn), 32'(acc));
    if (acc) chk("ImemAddr", 32'(ImemAddr), 32'(PcIn));
    chk("InstValid", 32'(InstValid), 32'(eval));
    if (eval) begin
      chk("InstPc", 32'(InstPc), 32'(q_pc[0]));
      chk("InstOut", 32'(InstOut), 32'(rom[q_pc[0]]));
    end
    chk("Done", 32'(Done), 32'(mstate == 2));
    @(posedge Clk);
    if (Reset) begin
      mstate = 0;
      clear_model();
    end else begin
      popd = eval && InstReady;
      hlt  = popd && (rom[q_pc[0]] == HALT_OP);
      if (popd) begin
        void'(q_pc.pop_front());
        void'(q_t.pop_front());
      end
      if (acc) begin
        q_pc.push_back(PcIn);
        q_t.push_back(cyc);
      end
      if (Start) begin
        mstate = 1;
        clear_model();
      end else if (hlt) begin
        mstate = 2;
        clear_model();
      end else if (Redirect) begin
        clear_model();
      end
    end
    cyc++;
    @(negedge Clk);
  endtask

  // Present addresses first..first+n-1 like a program counter; InstReady low
  // for the first `hold` cycles.
  task automatic feed(input int first, input int n, input int hold);
    int nxt = first;
    int k = 0;
    while (nxt < first + n && k < 60) begin
      PcValid   = 1'b1;
      PcIn      = L'(nxt);
      InstReady = (k >= hold);
      step();
      if (acc) nxt++;
      k++;
    end
    chk("feed_accepts", 32'(nxt), 32'(first + n));
    PcValid = 1'b0;
  endtask

  task automatic drain(input int n);
    PcValid   = 1'b0;
    InstReady = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    PcValid = 1'b0;
    PcIn    = '0;
    #1;
    chk({tag, "_PcReady"}, 32'(PcReady), 32'd0);
    chk({tag, "_ImemRdEn"}, 32'(ImemRdEn), 32'd0);
    chk({tag, "_ImemAddr"}, 32'(ImemAddr), 32'd0);
    chk({tag, "_InstValid"}, 32'(InstValid), 32'd0);
    chk({tag, "_InstOut"}, 32'(InstOut), 32'd0);
    chk({tag, "_InstPc"}, 32'(InstPc), 32'd0);
    chk({tag, "_Done"}, 32'(Done), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << L); i++) begin
      rom[i] = W'($urandom_range(0, 9'h1FE));
    end
    rom[0] = 9'h011;
    rom[1] = 9'h022;
    rom[2] = 9'h033;
    rom[3] = 9'h044;
    rom[7] = HALT_OP;

    Reset = 1'b1; Start = 1'b0; PcValid = 1'b0; PcIn = '0;
    Redirect = 1'b0; InstReady = 1'b0;
    mstate = 0; cyc = 0; clear_model();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_zero("reset");
    Reset = 1'b0;

    // Back-to-back stream with the decoder always ready.
    pulse_start();
    feed(0, 4, 0);
    drain(5);

    // Same stream with the decoder stalled for 5 cycles.
    pulse_start();
    feed(0, 4, 5);
    drain(6);

    // Redirect with 4 and 5 buffered and 6 in flight; new target 20.
    pulse_start();
    feed(4, 3, 100);
    PcValid = 1'b1; PcIn = L'(7); Redirect = 1'b1; InstReady = 1'b0;
    step();
    Redirect = 1'b0;
    feed(20, 3, 0);
    drain(5);

    // Halt opcode at address 7; address 8 must not be delivered.
    pulse_start();
    feed(6, 3, 0);
    drain(5);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_no_valid", 32'(InstValid), 32'd0);
    pulse_start();
    chk("restart_done_clear", 32'(Done), 32'd0);
    feed(0, 4, 0);
    drain(5);

    // Reset mid-run with 2 entries buffered and 1 read in flight.
    pulse_start();
    feed(30, 3, 100);
    PcValid = 1'b1; PcIn = L'(33); Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_zero("midreset");
    pulse_start();
    feed(40, 3, 0);
    drain(5);

    // Randomised traffic; small address range so the halt opcode is hit.
    for (int i = 0; i < 800; i++) begin
      PcValid   = ($urandom_range(0, 3) != 0);
      PcIn      = L'($urandom_range(0, 15));
      InstReady = ($urandom_range(0, 3) != 0);
      Redirect  = ($urandom_range(0, 15) == 0);
      Start     = ($urandom_range(0, 47) == 0) || (mstate != 1 && $urandom_range(0, 7) == 0);
      Reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    Start = 1'b0; Redirect = 1'b0; Reset = 1'b0;
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program-counter interface.
- Accepts fetch addresses from the program counter and issues reads to the synchronous instruction ROM, which has 1-cycle latency.
- Buffers each {pc, instruction} pair in a small prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Flushes wrong-path instructions on a taken branch (Redirect) and halts on the halt opcode.

Parameters:
- L, 10, instruction address width; matches the program counter width.
- W, 9, instruction word width.
- DEPTH, 3, prefetch FIFO entries; minimum 3 for full throughput.
- HALT_OP, 9'h1FF, opcode that ends the program.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; returns the block to IDLE.
- Start  in  1  begin a program; IDLE/HALT -> RUN, clears the FIFO.
- PcIn  in  L  fetch address from the program counter.
- PcValid  in  1  PcIn holds a valid fetch address.
- PcReady  out  1  unit accepts PcIn this cycle.
- Redirect  in  1  taken branch this cycle; flush the wrong path.
- ImemAddr  out  L  ROM address.
- ImemRdEn  out  1  ROM read strobe.
- ImemData  in  W  ROM data, valid 1 cycle after ImemRdEn.
- InstOut  out  W  instruction at the FIFO head.
- InstPc  out  L  address of InstOut.
- InstValid  out  1  InstOut/InstPc valid.
- InstReady  in  1  decoder consumes the head entry.
- Done  out  1  halt reached; held until Start or Reset.

Behaviour:
- Reset values:
  - state = IDLE; FIFO empty (count = 0, rd_ptr = wr_ptr = 0).
  - inflight = 0, kill = 0.
  - PcReady = 0, ImemRdEn = 0, ImemAddr = 0.
  - InstValid = 0, InstOut = 0, InstPc = 0, Done = 0.
- Reset has priority over Start, Redirect and every handshake. Reset mid-operation discards FIFO contents and any in-flight read.
- States:
  - IDLE: waits for Start.
  - RUN: fetching and delivering instructions.
  - HALT: Done = 1; no fetching or delivery.
- Transitions:
  - IDLE -Start-> RUN.
  - RUN -pop of HALT_OP-> HALT.
  - HALT -Start-> RUN.
  - Start while already in RUN: flush the FIFO and kill any in-flight read; remain in RUN.
- Issue:
  - PcReady = (state == RUN) && !Redirect && (count + inflight < DEPTH). The term is computed from registered state only, with no path from InstReady.
  - accept = PcValid && PcReady.
  - ImemRdEn = accept; ImemAddr = PcIn (combinational).
  - On accept, register the address as inflight_pc and set inflight = 1 for the next cycle.
- Response:
  - In the cycle after an accept, ImemData pairs with inflight_pc.
  - The pair is pushed at the wr_ptr unless kill is set.
  - inflight clears unless a new accept occurs in the same cycle.
- Latency:
  - Address accepted in cycle t; ROM data in cycle t+1; InstValid = 1 in cycle t+2.
  - Sustained throughput is 1 instruction/cycle when InstReady = 1 and PcValid = 1.
- Delivery:
  - InstValid = (state == RUN) && (count != 0); InstOut/InstPc come from the rd_ptr entry.
  - pop = InstValid && InstReady.
  - Head entry and its outputs stay stable while InstValid = 1 && InstReady = 0.
- Simultaneous push and pop: allowed in the same cycle; count is unchanged.
- Full: the credit rule guarantees no push when count == DEPTH. A push while full is an assertion failure.
- Empty: InstValid = 0; a pop while empty cannot occur.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- Redirect:
  - In the cycle Redirect = 1, the FIFO is cleared, and kill is set for an in-flight read landing next cycle.
  - PcReady = 0 that cycle, so the pre-branch PcIn is ignored.
  - A pop in the Redirect cycle still completes; the decoder owns that instruction.
  - The new target is accepted from the next cycle.
- Halt:
  - Popping HALT_OP enters HALT and flushes the FIFO, killing any in-flight read; Done = 1 from the next cycle.
  - Redirect in the same cycle as a halt pop: the halt wins.

Decomposition:
- Shared package fetch_pkg holds:
  - constants L, W, HALT_OP;
  - typedef fetch_entry_t = struct {logic [L-1:0] pc; logic [W-1:0] inst};
  - typedef fetch_state_t = enum {IDLE, RUN, HALT}.
- One sub-module: fetch_fifo. It is a parameterised DEPTH x fetch_entry_t circular buffer with push, pop, flush, count, head. Flush takes priority over push.
- The top level holds the FSM, the credit logic, the inflight/kill register and the ROM interface.

Test Plan:
- Reset, then Start. PcIn = 0,1,2,3 with PcValid held high and InstReady = 1. ROM holds 9'h011, 9'h022, 9'h033, 9'h044 at those addresses.
  - Required: ImemRdEn on 4 consecutive cycles.
  - Required: InstValid from cycle 2 after the first accept, delivering (0,9'h011) through (3,9'h044) back-to-back.
- Same stream with InstReady = 0 for 5 cycles.
  - Required: PcReady drops once count + inflight = 3.
  - Required: the head stays at (0,9'h011) and no entry is lost.
  - Required: after release, order is intact.
- Redirect pulsed while entries for addresses 4 and 5 are buffered and 6 is in flight; new PcIn = 20.
  - Required: 5 and 6 are never presented (4 only if popped in the Redirect cycle).
  - Required: the next InstValid shows InstPc = 20.
- ROM[7] = 9'h1FF; fetch 6, 7, 8.
  - Required: 9'h1FF is delivered, then Done = 1 and state HALT, with InstValid = 0.
  - Required: address 8 is not delivered. A subsequent Start clears Done and restarts fetch.
- Reset asserted mid-run with 2 entries buffered and 1 read in flight.
  - Required: next cycle all outputs are 0 and Done = 0.
  - Required: no stale instruction appears after Start.
